// File: rtl/tick_divider_pkg.sv
// rtl/tick_divider_pkg.sv - shared defaults and board divisor constants for tick_divider
//
// Purpose: default parameter values for tick_divider and tick_subcounter, plus
// divisor constants for the 12 MHz board clock (period = divisor + 1 cycles).
// Ports: none (package).

package tick_divider_pkg;

    localparam int BOARD_CLK_HZ  = 12_000_000;

    localparam int DEF_CTR_WIDTH = 24;
    localparam int DEF_DIV       = 5_000_000;
    localparam int DEF_SUB_COUNT = 10;
    localparam int DEF_SUB_WIDTH = 4;

    // Divisors give exactly 10 Hz / 1 Hz primary ticks on the board clock.
    localparam int DIV_10HZ      = BOARD_CLK_HZ / 10 - 1;
    localparam int DIV_1HZ       = BOARD_CLK_HZ - 1;

    // Ten 10 Hz ticks make one 1 Hz slow tick.
    localparam int SUB_10HZ_TO_1HZ = 10;

endpackage

// File: rtl/tick_subcounter.sv
// rtl/tick_subcounter.sv - cascaded divide-by-SUB_COUNT stage producing a slow tick
//
// Purpose: counts step pulses and emits a registered one-cycle slow_tick on
// every SUB_COUNT-th step, coincident with the step's registered tick.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   restart   in   re-phase: reload to SUB_COUNT-1, clear slow_tick
//   step      in   one-cycle advance pulse (primary terminal event)
//   slow_tick out  registered one-cycle pulse

module tick_subcounter
    import tick_divider_pkg::*;
#(
    parameter int SUB_COUNT = DEF_SUB_COUNT,
    parameter int SUB_WIDTH = DEF_SUB_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic step,
    output logic slow_tick
);

    localparam logic [SUB_WIDTH-1:0] SUB_RELOAD = SUB_WIDTH'(SUB_COUNT - 1);

    logic [SUB_WIDTH-1:0] sub_count_q, sub_count_d;
    logic                 slow_tick_q, slow_tick_d;

    always_comb begin
        sub_count_d = sub_count_q;
        slow_tick_d = 1'b0;
        if (restart) begin
            sub_count_d = SUB_RELOAD;
        end else if (step) begin
            if (sub_count_q == '0) begin
                slow_tick_d = 1'b1;
                sub_count_d = SUB_RELOAD;
            end else begin
                sub_count_d = sub_count_q - SUB_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_count_q <= SUB_RELOAD;
            slow_tick_q <= 1'b0;
        end else begin
            sub_count_q <= sub_count_d;
            slow_tick_q <= slow_tick_d;
        end
    end

    assign slow_tick = slow_tick_q;

endmodule

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - down-counting tick generator with loadable divisor and slow-tick cascade
//
// Purpose: emits a one-cycle tick every div+1 enabled cycles; the divisor is
// loaded through a ready/valid port and held in a shadow register until the
// next terminal count or restart, so a running period is never truncated.
// Optional build macro TICK_DIVIDER_SQUARE_EN adds a 50% duty square output.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   en         in   count enable (low pauses both counters)
//   restart    in   synchronous re-phase of both counters
//   load_div   in   new divisor value
//   load_valid in   load request
//   load_ready out  high when no load is pending
//   tick       out  registered one-cycle primary pulse
//   slow_tick  out  registered pulse every SUB_COUNT ticks
//   cur_div    out  divisor currently in effect
//   square     out  (TICK_DIVIDER_SQUARE_EN only) toggles on each tick

module tick_divider
    import tick_divider_pkg::*;
#(
    parameter int CTR_WIDTH   = DEF_CTR_WIDTH,
    parameter int DEFAULT_DIV = DEF_DIV,
    parameter int SUB_COUNT   = DEF_SUB_COUNT,
    parameter int SUB_WIDTH   = DEF_SUB_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 restart,
    input  logic [CTR_WIDTH-1:0] load_div,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic                 tick,
    output logic                 slow_tick,
    output logic [CTR_WIDTH-1:0] cur_div
`ifdef TICK_DIVIDER_SQUARE_EN
    ,
    output logic                 square
`endif
);

    localparam logic [CTR_WIDTH-1:0] DIV_RST = CTR_WIDTH'(DEFAULT_DIV);

    logic [CTR_WIDTH-1:0] count_q, count_d;
    logic [CTR_WIDTH-1:0] div_active_q, div_active_d;
    logic [CTR_WIDTH-1:0] shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic                 tick_q, tick_d;

    logic                 accept;
    logic                 term;
    logic [CTR_WIDTH-1:0] reload_val;
    logic [CTR_WIDTH-1:0] restart_val;

    always_comb begin
        accept      = load_valid && !pending_q;
        term        = en && (count_q == '0) && !restart;
        reload_val  = pending_q ? shadow_q : div_active_q;
        // A load accepted together with restart bypasses the shadow entirely.
        restart_val = accept ? load_div : reload_val;

        count_d      = count_q;
        div_active_d = div_active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        tick_d       = 1'b0;

        if (restart) begin
            count_d      = restart_val;
            div_active_d = restart_val;
            pending_d    = 1'b0;
            if (accept) begin
                shadow_d = load_div;
            end
        end else begin
            if (term) begin
                count_d      = reload_val;
                div_active_d = reload_val;
                pending_d    = 1'b0;
                tick_d       = 1'b1;
            end else if (en) begin
                count_d = count_q - CTR_WIDTH'(1);
            end
            // Placed after the reload so a load coinciding with the terminal
            // event becomes pending for the following period.
            if (accept) begin
                shadow_d  = load_div;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= DIV_RST;
            div_active_q <= DIV_RST;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            count_q      <= count_d;
            div_active_q <= div_active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            tick_q       <= tick_d;
        end
    end

`ifdef TICK_DIVIDER_SQUARE_EN
    logic square_q, square_d;

    always_comb begin
        square_d = square_q;
        if (restart) begin
            square_d = 1'b0;
        end else if (term) begin
            square_d = ~square_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            square_q <= 1'b0;
        end else begin
            square_q <= square_d;
        end
    end

    assign square = square_q;
`endif

    tick_subcounter #(
        .SUB_COUNT (SUB_COUNT),
        .SUB_WIDTH (SUB_WIDTH)
    ) u_sub (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .step      (term),
        .slow_tick (slow_tick)
    );

    assign load_ready = !pending_q;
    assign tick       = tick_q;
    assign cur_div    = div_active_q;

endmodule

// File: tb/tb_tick_divider.sv
// tb/tb_tick_divider.sv - directed self-checking bench for tick_divider

module tb_tick_divider;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          restart;
    logic [CW-1:0] load_div;
    logic          load_valid;
    logic          load_ready;
    logic          tick;
    logic          slow_tick;
    logic [CW-1:0] cur_div;
`ifdef TICK_DIVIDER_SQUARE_EN
    logic          square;
`endif

    int checks = 0;
    int errors = 0;

    tick_divider #(
        .CTR_WIDTH   (CW),
        .DEFAULT_DIV (3),
        .SUB_COUNT   (4),
        .SUB_WIDTH   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .restart    (restart),
        .load_div   (load_div),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .tick       (tick),
        .slow_tick  (slow_tick),
        .cur_div    (cur_div)
`ifdef TICK_DIVIDER_SQUARE_EN
        ,
        .square     (square)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset released and en high; the next edge is cycle 1.
    task automatic do_reset();
        reset = 1'b1; en = 1'b0; restart = 1'b0;
        load_valid = 1'b0; load_div = '0;
        cyc(); cyc();
        reset = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; restart = 1'b1;
        load_valid = 1'b1; load_div = 8'd9;
        cyc(); cyc();
        checks++;
        if (tick !== 1'b0 || slow_tick !== 1'b0 || load_ready !== 1'b1 || cur_div !== 8'd3) begin
            errors++;
            $display("FAIL reset_state: tick=%b slow=%b ready=%b cur_div=%0d, want 0 0 1 3",
                     tick, slow_tick, load_ready, cur_div);
        end
`ifdef TICK_DIVIDER_SQUARE_EN
        checks++;
        if (square !== 1'b0) begin
            errors++;
            $display("FAIL reset_square: got %b want 0", square);
        end
`endif
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            cyc();
            checks++;
            if (tick !== (k % 4 == 0) || slow_tick !== (k == 16)) begin
                errors++;
                $display("FAIL basic_cycle%0d: tick=%b slow=%b want %b %b",
                         k, tick, slow_tick, (k % 4 == 0), (k == 16));
            end
`ifdef TICK_DIVIDER_SQUARE_EN
            checks++;
            if (square !== ((k / 4) % 2 == 1)) begin
                errors++;
                $display("FAIL basic_square%0d: got %b want %b", k, square, ((k / 4) % 2 == 1));
            end
`endif
        end
    endtask

    task automatic test_pause();
        do_reset();
        cyc();                              // count = 2
        en = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            cyc();
            checks++;
            if (tick !== 1'b0 || slow_tick !== 1'b0) begin
                errors++;
                $display("FAIL pause_cycle%0d: tick=%b slow=%b want 0 0", k, tick, slow_tick);
            end
        end
        en = 1'b1;
        for (int k = 7; k <= 9; k++) begin
            cyc();
            checks++;
            if (tick !== (k == 9)) begin
                errors++;
                $display("FAIL pause_resume%0d: tick=%b want %b", k, tick, (k == 9));
            end
        end
    endtask

    task automatic test_load();
        do_reset();
        cyc();                              // count = 2
        load_div = 8'd1; load_valid = 1'b1;
        cyc();                              // cycle 2: accepted
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0 || cur_div !== 8'd3) begin
            errors++;
            $display("FAIL load_pending: ready=%b cur_div=%0d want 0 3", load_ready, cur_div);
        end
        cyc();                              // cycle 3
        cyc();                              // cycle 4: old period completes
        checks++;
        if (tick !== 1'b1 || cur_div !== 8'd1 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_apply: tick=%b cur_div=%0d ready=%b want 1 1 1",
                     tick, cur_div, load_ready);
        end
        for (int k = 5; k <= 8; k++) begin
            cyc();
            checks++;
            if (tick !== (k % 2 == 0)) begin
                errors++;
                $display("FAIL load_period%0d: tick=%b want %b", k, tick, (k % 2 == 0));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        cyc();
        load_div = 8'd1; load_valid = 1'b1;
        cyc();                              // cycle 2: first load accepted
        load_div = 8'd2;                    // second request held off
        cyc();                              // cycle 3
        checks++;
        if (load_ready !== 1'b0 || cur_div !== 8'd3) begin
            errors++;
            $display("FAIL stall_hold: ready=%b cur_div=%0d want 0 3", load_ready, cur_div);
        end
        cyc();                              // cycle 4: terminal, shadow=1 applied
        checks++;
        if (tick !== 1'b1 || cur_div !== 8'd1 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_first: tick=%b cur_div=%0d ready=%b want 1 1 1",
                     tick, cur_div, load_ready);
        end
        cyc();                              // cycle 5: second load accepted
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL stall_second_accept: ready=%b tick=%b want 0 0", load_ready, tick);
        end
        cyc();                              // cycle 6: terminal, divisor 2 applied
        checks++;
        if (tick !== 1'b1 || cur_div !== 8'd2) begin
            errors++;
            $display("FAIL stall_second_apply: tick=%b cur_div=%0d want 1 2", tick, cur_div);
        end
        for (int k = 7; k <= 9; k++) begin
            cyc();
            checks++;
            if (tick !== (k == 9)) begin
                errors++;
                $display("FAIL stall_period%0d: tick=%b want %b", k, tick, (k == 9));
            end
        end
    endtask

    task automatic test_load_at_terminal();
        do_reset();
        cyc(); cyc(); cyc();                // count = 0
        load_div = 8'd1; load_valid = 1'b1;
        cyc();                              // cycle 4: terminal and accept together
        load_valid = 1'b0;
        checks++;
        if (tick !== 1'b1 || cur_div !== 8'd3 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL term_load: tick=%b cur_div=%0d ready=%b want 1 3 0",
                     tick, cur_div, load_ready);
        end
        for (int k = 5; k <= 10; k++) begin
            cyc();
            checks++;
            if (tick !== (k == 8 || k == 10)) begin
                errors++;
                $display("FAIL term_load_cycle%0d: tick=%b want %b", k, tick, (k == 8 || k == 10));
            end
        end
        checks++;
        if (cur_div !== 8'd1) begin
            errors++;
            $display("FAIL term_load_div: cur_div=%0d want 1", cur_div);
        end
    endtask

    task automatic test_restart_load();
        do_reset();
        for (int k = 1; k <= 6; k++) cyc(); // one tick at 4, sub advanced
        restart = 1'b1; load_valid = 1'b1; load_div = 8'd5;
        cyc();                              // cycle 7: restart
        restart = 1'b0; load_valid = 1'b0;
        checks++;
        if (tick !== 1'b0 || slow_tick !== 1'b0 || cur_div !== 8'd5 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_state: tick=%b slow=%b cur_div=%0d ready=%b want 0 0 5 1",
                     tick, slow_tick, cur_div, load_ready);
        end
`ifdef TICK_DIVIDER_SQUARE_EN
        checks++;
        if (square !== 1'b0) begin
            errors++;
            $display("FAIL restart_square: got %b want 0", square);
        end
`endif
        for (int k = 8; k <= 31; k++) begin
            cyc();
            checks++;
            if (tick !== ((k - 7) % 6 == 0) || slow_tick !== (k == 31)) begin
                errors++;
                $display("FAIL restart_cycle%0d: tick=%b slow=%b want %b %b",
                         k, tick, slow_tick, ((k - 7) % 6 == 0), (k == 31));
            end
        end
    endtask

    task automatic test_div_zero();
        do_reset();
        cyc();
        restart = 1'b1; load_valid = 1'b1; load_div = 8'd0;
        cyc();
        restart = 1'b0; load_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            checks++;
            if (tick !== 1'b1 || cur_div !== 8'd0) begin
                errors++;
                $display("FAIL div_zero%0d: tick=%b cur_div=%0d want 1 0", k, tick, cur_div);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc();
        load_div = 8'd7; load_valid = 1'b1;
        cyc();                              // load pending
        load_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++;
        if (tick !== 1'b0 || slow_tick !== 1'b0 || load_ready !== 1'b1 || cur_div !== 8'd3) begin
            errors++;
            $display("FAIL reset_mid_state: tick=%b slow=%b ready=%b cur_div=%0d want 0 0 1 3",
                     tick, slow_tick, load_ready, cur_div);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            checks++;
            if (tick !== (k % 4 == 0) || cur_div !== 8'd3) begin
                errors++;
                $display("FAIL reset_mid_cycle%0d: tick=%b cur_div=%0d want %b 3",
                         k, tick, cur_div, (k % 4 == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_load();
        test_stall();
        test_load_at_terminal();
        test_restart_load();
        test_div_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
